// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage. Owns the program counter and issues sequential
//   word fetches to instruction memory over a valid/ready handshake. Returned
//   instructions are buffered in a small FIFO tagged with their PC. One
//   instruction per cycle is presented to decode through the fetch-to-decode
//   register. Redirects from decode flush the FIFO, retarget the PC, and
//   discard every wrong-path response still in flight.
//
// Parameters
//   XLEN       data / address width
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  FIFO entries and max in-flight requests (power of 2, >= 2)
//   NOP_INSN   instruction presented when no valid instruction is held
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_resp_*       in-order response channel, at least 1 cycle after accept
//   f_to_d_enable_ff  1 = load the fetch-to-decode register, 0 = hold it
//   redirect_*        taken jump/branch target from decode
//   instruction       registered instruction to decode
//   PC_out            registered PC of that instruction
//   instr_valid       instruction/PC_out hold a real fetched instruction
module fetch_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
  parameter int unsigned       BUF_DEPTH = 4,
  parameter logic [XLEN-1:0]   NOP_INSN  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            f_to_d_enable_ff,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] PC_out,
  output logic            instr_valid
);

  localparam int unsigned     CW        = $clog2(BUF_DEPTH + 1);
  localparam int unsigned     PW        = $clog2(BUF_DEPTH);
  localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(BUF_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  // Program counters and request/response bookkeeping
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_count;

  // Instruction FIFO
  logic [XLEN-1:0] pc_mem   [BUF_DEPTH];
  logic [XLEN-1:0] insn_mem [BUF_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   fifo_count;

  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            resp_drop;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic            fifo_full;

  // Request side. In-flight requests plus buffered instructions never exceed
  // BUF_DEPTH, so every response has a FIFO slot waiting for it.
  always_comb begin
    occupancy      = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_OCC);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !imem_resp_valid) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!req_fire && imem_resp_valid) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // A response arriving in a redirect cycle is wrong-path and is neither
  // pushed nor counted into drop_count (outstanding_nxt already excludes it).
  always_comb begin
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == DEPTH_CNT);
    resp_drop  = imem_resp_valid && (drop_count != '0);
    fifo_push  = imem_resp_valid && (drop_count == '0) && !redirect_valid;
    fifo_pop   = !redirect_valid && f_to_d_enable_ff && !fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc;
        resp_pc    <= redirect_pc;
        drop_count <= outstanding_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (resp_drop) begin
          drop_count <= drop_count - CW'(1);
        end else if (fifo_push) begin
          resp_pc <= resp_pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (fifo_push && !fifo_pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (!fifo_push && fifo_pop) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read when fifo_count says so.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      insn_mem[wr_ptr] <= imem_resp_data;
    end
  end

  // Fetch-to-decode register. Reads only the FIFO head, never the incoming
  // response, so a response reaches decode no earlier than two cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instruction <= NOP_INSN;
      PC_out      <= RESET_PC;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      instruction <= NOP_INSN;
    end else if (f_to_d_enable_ff) begin
      if (!fifo_empty) begin
        instr_valid <= 1'b1;
        instruction <= insn_mem[rd_ptr];
        PC_out      <= pc_mem[rd_ptr];
      end else begin
        instr_valid <= 1'b0;
        instruction <= NOP_INSN;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (outstanding == '0)));

endmodule
